// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among N_REQ
// byte requesters; grant is held across a frame until its last byte.
// Ports: i_Clock/i_Rst_n; per-requester i_Req, i_Req_Byte,
// i_Req_Last, o_Ack; o_Grant/o_Busy status; o_Tx_DV/o_Tx_Byte and
// i_Tx_Done toward uart_tx; o_Frame_Abort on hold timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_Req_Byte,
  input  logic [N_REQ-1:0]   i_Req_Last,
  output logic [N_REQ-1:0]   o_Ack,
  output logic [N_REQ-1:0]   o_Grant,
  output logic               o_Busy,
  output logic               o_Tx_DV,
  output logic [7:0]         o_Tx_Byte,
  input  logic               i_Tx_Done,
  output logic               o_Frame_Abort
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_TIMEOUT > 0) ?
                      $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              dv_q, dv_d;
  logic [7:0]        byte_q, byte_d;
  logic              abort_q, abort_d;
  logic              last_q, last_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     own_q, own_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              found;
  logic [IW-1:0]     win;
  int                kk;

  // First requester after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    kk    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      kk = int'(ptr_q) + i;
      if (kk >= N_REQ) kk = kk - N_REQ;
      if (!found && i_Req[kk[IW-1:0]]) begin
        found = 1'b1;
        win   = kk[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    abort_d = 1'b0;
    last_d  = last_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          own_d   = win;
          grant_d = ONE << win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_d  = i_Req_Byte[{own_q, 3'b000} +: 8];
        last_d  = i_Req_Last[own_q];
        dv_d    = 1'b1;
        ack_d   = ONE << own_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          if (last_q || HOLD_TIMEOUT == 0) begin
            grant_d = '0;
            ptr_d   = own_q;
            state_d = S_IDLE;
          end else if (i_Req[own_q]) begin
            state_d = S_LOAD;
          end else begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (i_Req[own_q]) begin
          state_d = S_LOAD;
        end else if (int'(cnt_q) + 1 >= HOLD_TIMEOUT - 1) begin
          // Owner went quiet mid-frame: give the line back.
          abort_d = 1'b1;
          grant_d = '0;
          ptr_d   = own_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= 8'h00;
      abort_q <= 1'b0;
      last_q  <= 1'b0;
      ptr_q   <= IW'(N_REQ - 1);
      own_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      abort_q <= abort_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Ack         = ack_q;
  assign o_Grant       = grant_q;
  assign o_Busy        = busy_q;
  assign o_Tx_DV       = dv_q;
  assign o_Tx_Byte     = byte_q;
  assign o_Frame_Abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of
// uart_tx_arbiter against a frame-level round-robin model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        dv;
  logic [7:0]  tx_byte;
  logic        done = 1'b0;
  logic        abort;

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0] items [4][16];
  int         cnt [4];
  int         rd [4];
  logic [7:0] exp_b [$];
  int         exp_k [$];

  uart_tx_arbiter #(
    .N_REQ(4),
    .HOLD_TIMEOUT(8)
  ) dut (
    .i_Clock(clk),
    .i_Rst_n(rst_n),
    .i_Req(req),
    .i_Req_Byte(req_byte),
    .i_Req_Last(req_last),
    .o_Ack(ack),
    .o_Grant(grant),
    .o_Busy(busy),
    .o_Tx_DV(dv),
    .o_Tx_Byte(tx_byte),
    .i_Tx_Done(done),
    .o_Frame_Abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_last = '0;
    req_byte = '0;
    done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic present(input int k);
    req[k] = 1'b1;
    req_byte[8*k +: 8] = items[k][rd[k]][7:0];
    req_last[k] = items[k][rd[k]][8];
  endtask

  // Frame-level round robin: whole frames, pointer starts at 3.
  task automatic build_exp();
    int mrd [4];
    int ptr;
    int k;
    bit any;
    bit fin;
    ptr = 3;
    for (int i = 0; i < 4; i++) mrd[i] = 0;
    forever begin
      any = 1'b0;
      k = 0;
      for (int i = 1; i <= 4; i++) begin
        if (!any && mrd[(ptr + i) % 4] < cnt[(ptr + i) % 4]) begin
          any = 1'b1;
          k = (ptr + i) % 4;
        end
      end
      if (!any) break;
      fin = 1'b0;
      while (!fin && mrd[k] < cnt[k]) begin
        exp_b.push_back(items[k][mrd[k]][7:0]);
        exp_k.push_back(k);
        fin = items[k][mrd[k]][8];
        mrd[k]++;
      end
      ptr = k;
    end
  endtask

  task automatic run_engine(input string name);
    int cyc;
    int done_at;
    int gap [4];
    bit abort_seen;
    logic [7:0] eb;
    int ek;
    bit was_last;
    exp_b.delete();
    exp_k.delete();
    build_exp();
    abort_seen = 1'b0;
    done_at = -1;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      rd[k] = 0;
      gap[k] = 0;
      if (cnt[k] > 0) present(k);
    end
    while ((exp_b.size() > 0 || busy) && cyc < 3000) begin
      tick();
      cyc++;
      if (abort) abort_seen = 1'b1;
      if (dv) begin
        if (exp_b.size() == 0) begin
          chk({name, "_extra_dv"}, 1, 0);
        end else begin
          eb = exp_b.pop_front();
          ek = exp_k.pop_front();
          chk({name, "_byte"}, tx_byte, eb);
          chk({name, "_ack"}, ack, 1 << ek);
          chk({name, "_grant"}, grant, 1 << ek);
        end
        done_at = cyc + $urandom_range(2, 6);
      end
      done = (cyc == done_at);
      for (int k = 0; k < 4; k++) begin
        if (ack[k]) begin
          was_last = items[k][rd[k]][8];
          rd[k]++;
          gap[k] = (!was_last) ? $urandom_range(0, 3) : 0;
          if (rd[k] < cnt[k] && gap[k] == 0) present(k);
          else req[k] = 1'b0;
        end else if (!req[k] && rd[k] < cnt[k] && gap[k] > 0) begin
          gap[k]--;
          if (gap[k] == 0) present(k);
        end
      end
    end
    done = 1'b0;
    chk({name, "_drained"}, exp_b.size(), 0);
    chk({name, "_idle"}, busy, 0);
    chk({name, "_no_abort"}, abort_seen, 0);
  endtask

  int n;
  bit bad;

  initial begin
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dv", dv, 0);
    chk("rst_ack", ack, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_abort", abort, 0);

    // Single byte from requester 2.
    req[2] = 1'b1;
    req_byte[23:16] = 8'hAB;
    req_last[2] = 1'b1;
    tick();
    chk("single_grant", grant, 4'b0100);
    chk("single_busy", busy, 1);
    chk("single_dv_early", dv, 0);
    tick();
    chk("single_dv", dv, 1);
    chk("single_byte", tx_byte, 8'hAB);
    chk("single_ack", ack, 4'b0100);
    req = '0;
    tick();
    chk("single_dv_pulse", dv, 0);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_rel_grant", grant, 0);
    chk("single_rel_busy", busy, 0);

    // Round robin: one-byte frames from everybody, twice.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cnt[k] = (k == 0) ? 2 : 1;
      items[k][0] = {1'b1, 8'h10 + 8'(k)};
      items[k][1] = {1'b1, 8'h20 + 8'(k)};
    end
    run_engine("rr");

    // Frame hold: req0 three-byte frame, req1 waiting.
    do_reset();
    cnt[0] = 3;
    items[0][0] = {1'b0, 8'h3D};
    items[0][1] = {1'b0, 8'h3E};
    items[0][2] = {1'b1, 8'h3F};
    cnt[1] = 1;
    items[1][0] = {1'b1, 8'h41};
    cnt[2] = 0;
    cnt[3] = 0;
    run_engine("hold");

    // Timeout: req0 leaves its frame open.
    do_reset();
    req[0] = 1'b1;
    req_byte[7:0] = 8'h55;
    req_last[0] = 1'b0;
    tick();
    chk("to_grant0", grant, 4'b0001);
    tick();
    chk("to_byte", tx_byte, 8'h55);
    req = '0;
    tick();
    tick();
    req[1] = 1'b1;
    req_byte[15:8] = 8'h66;
    req_last[1] = 1'b1;
    done = 1'b1;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      done = 1'b0;
      if (abort) break;
    end
    chk("to_abort_delay", n, 8);
    chk("to_grant_clr", grant, 0);
    tick();
    chk("to_abort_pulse", abort, 0);
    chk("to_grant1", grant, 4'b0010);
    tick();
    chk("to_byte1", tx_byte, 8'h66);
    req = '0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("to_idle", busy, 0);

    // Back-to-back: owner requesting in the Done cycle.
    do_reset();
    req[0] = 1'b1;
    req_byte[7:0] = 8'h61;
    req_last[0] = 1'b0;
    tick();
    tick();
    chk("b2b_byte0", tx_byte, 8'h61);
    req_byte[7:0] = 8'h62;
    req_last[0] = 1'b1;
    tick();
    done = 1'b1;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      done = 1'b0;
      if (dv) break;
    end
    chk("b2b_spacing", n, 2);
    chk("b2b_byte1", tx_byte, 8'h62);
    req = '0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("b2b_idle", busy, 0);

    // Reset while waiting for Done.
    do_reset();
    req[3] = 1'b1;
    req_byte[31:24] = 8'h77;
    req_last[3] = 1'b1;
    tick();
    tick();
    req = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        {ack, grant, busy, dv, tx_byte, abort}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    done = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      tick();
      done = 1'b0;
      if (dv || busy) bad = 1'b1;
    end
    chk("mid_rst_stale_done", bad, 0);

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int k = 0; k < 4; k++) begin
        int nf;
        int len;
        cnt[k] = 0;
        nf = $urandom_range(0, 3);
        if (r == 0 && k == 0 && nf == 0) nf = 1;
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) begin
            items[k][cnt[k]] = {j == len - 1, 8'($urandom)};
            cnt[k]++;
          end
        end
      end
      run_engine("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx serializer among N byte requesters.
- Accepts bytes over per-requester req/ack handshakes and drives the serializer's i_Tx_DV/i_Tx_Byte.
- Waits for the serializer's o_Tx_Done before each next byte.
- Holds the grant across multi-byte frames until the frame's last byte, so frames are never interleaved on the line.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_TIMEOUT, 1024, idle cycles a granted requester may leave between frame bytes before the grant is revoked; 0 means release after every byte.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge.
- i_Rst_n  input  1  reset, asynchronous, active-low.
- i_Req  input  N_REQ  per-requester "byte available"; must hold until its o_Ack.
- i_Req_Byte  input  8*N_REQ  requester k's byte on bits [8k+7:8k].
- i_Req_Last  input  N_REQ  marks the presented byte as last of its frame.
- o_Ack  output  N_REQ  one-cycle pulse: the byte was taken.
- o_Grant  output  N_REQ  one-hot current owner; all zero when idle.
- o_Busy  output  1  high in any state other than IDLE.
- o_Tx_DV  output  1  one-cycle start pulse to uart_tx.
- o_Tx_Byte  output  8  byte to uart_tx; stable from the o_Tx_DV cycle until o_Tx_Done.
- i_Tx_Done  input  1  uart_tx o_Tx_Done, one-cycle pulse after the stop bit.
- o_Frame_Abort  output  1  one-cycle pulse when the grant is revoked by timeout.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - o_Ack, o_Grant, o_Busy, o_Tx_DV, o_Frame_Abort = 0; o_Tx_Byte = 8'h00.
  - RR pointer = N_REQ-1, so requester 0 has highest priority first.
  - Hold counter = 0.
  - Reset mid-byte abandons the transfer; uart_tx finishes on its own, and later Done pulses are ignored in IDLE.
- IDLE:
  - If any i_Req bit is set, pick the first set bit searching from pointer+1 upward with wrap.
  - Next edge: o_Grant = one-hot(winner), go LOAD.
- LOAD (exactly one cycle):
  - Register the winner's byte into o_Tx_Byte and its i_Req_Last into last_q.
  - Assert o_Tx_DV = 1 and o_Ack[owner] = 1 for this cycle only.
  - Go WAIT_DONE.
- WAIT_DONE:
  - i_Req changes are ignored.
  - On i_Tx_Done:
    - if last_q = 1 or HOLD_TIMEOUT = 0: clear o_Grant, pointer = owner, go IDLE;
    - else if i_Req[owner] = 1 in the same cycle: go LOAD directly, with no idle gap;
    - else go HOLD with counter = 0.
- HOLD:
  - If i_Req[owner] = 1, go LOAD.
  - Else increment the counter; when it reaches HOLD_TIMEOUT-1, pulse o_Frame_Abort, clear o_Grant, pointer = owner, go IDLE.
  - Other requesters are never serviced in HOLD.
- Minimum spacing between consecutive o_Tx_DV pulses: 2 cycles after i_Tx_Done (Done, LOAD).
- Releasing from IDLE re-arbitrates on the next cycle. A requester re-asserting immediately after release has lowest priority.
- i_Tx_Done outside WAIT_DONE is ignored.
- A requester lowering i_Req before its ack is legal. It loses the request only if the request was not yet sampled in LOAD.
- Counter width: $clog2(HOLD_TIMEOUT+1).

Test Plan:
- Single byte: reset, i_Req[2] = 1, byte 8'hAB, Last = 1.
  - o_Grant = 4'b0100 one cycle later, then one o_Tx_DV with o_Tx_Byte = 8'hAB and o_Ack[2] pulse.
  - After the model's Done: o_Grant = 0, o_Busy = 0.
- Round robin: i_Req = 4'b1111 continuously, all Last = 1.
  - Serve order is 0, 1, 2, 3, 0; bytes 8'h10..8'h13 appear in that order.
- Frame hold: req0 sends 8'h3D, 8'h3E, 8'h3F (Last on the third) while req1 stays requesting.
  - All three bytes go out before req1's first byte; req0 is granted continuously.
- Timeout: HOLD_TIMEOUT = 8; req0 sends 8'h55 with Last = 0, then drops.
  - o_Frame_Abort pulses 8 cycles after Done; the next grant goes to req1.
- Back-to-back: owner's i_Req is high in the same cycle as i_Tx_Done.
  - o_Tx_DV reasserts exactly 2 cycles after Done.
- Reset mid-transfer: assert i_Rst_n = 0 in WAIT_DONE.
  - All outputs are 0 immediately (async); the stale Done after release causes no o_Tx_DV.
